// File: rtl/riscv_pkg.sv
// Shared definitions for the UART instruction loader: sync byte, default imem
// address width and the state encodings of the byte receiver and loader FSMs.
package riscv_pkg;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;
  localparam int         IMEM_ADDR_W      = 10;

  typedef enum logic [2:0] {
    L_SYNC,
    L_LEN0,
    L_LEN1,
    L_DATA,
    L_CSUM,
    L_DONE,
    L_ERR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchroniser, falling-edge start detect,
// mid-bit sampling; emits a one-cycle byte_valid or frame_err per frame.
module uart_rx_byte
  import riscv_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t        state;
  rx_state_t        next_state;
  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clear;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // A start needs a genuine high-to-low edge, so a low stop bit left on the
  // line after a framing error cannot retrigger the receiver.
  always_comb begin
    next_state = state;
    cnt_clear  = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_clear = 1'b1;
        if (rx_prev && !rx_sync) next_state = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_M1) begin
          cnt_clear  = 1'b1;
          next_state = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_clear = 1'b1;
          if (bit_idx == 3'd7) next_state = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_clear  = 1'b1;
          next_state = RX_IDLE;
        end
      end
      default: next_state = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'd0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      frame_err  <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= cnt_clear ? '0 : cnt + CNT_W'(1);
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == RX_START) bit_idx <= 3'd0;
      if (state == RX_DATA && cnt == FULL_M1) begin
        shift_reg <= {rx_sync, shift_reg[7:1]};
        bit_idx   <= bit_idx + 3'd1;
      end
      if (state == RX_STOP && cnt == FULL_M1) begin
        if (rx_sync) begin
          byte_valid <= 1'b1;
          byte_data  <= shift_reg;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_instr_loader.sv
// UART boot loader: parses A5/LEN/data frames, writes 32-bit words to imem and
// holds the core until the image is in. Define RISCV_LOADER_CHECKSUM_EN for a trailing XOR byte.
module uart_instr_loader
  import riscv_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter int ADDR_W      = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_instr,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              frame_err;
  loader_state_t     state;
  loader_state_t     next_state;
  logic [7:0]        len_lo;
  logic [15:0]       len_n;
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_idx;
  logic [23:0]       word_buf;
  logic              is_sync;
`ifdef RISCV_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign len_n   = {byte_data, len_lo};
  assign is_sync = (byte_data == LOADER_SYNC_BYTE);

  always_comb begin
    next_state = state;
    if (frame_err) begin
      if (state != L_SYNC && state != L_DONE) next_state = L_ERR;
    end else if (byte_valid) begin
      case (state)
        L_SYNC:  if (is_sync) next_state = L_LEN0;
        L_LEN0:  next_state = L_LEN1;
        L_LEN1: begin
          if (len_n == 16'd0) begin
`ifdef RISCV_LOADER_CHECKSUM_EN
            next_state = L_CSUM;
`else
            next_state = L_DONE;
`endif
          end else if ({1'b0, len_n} > MAX_WORDS) begin
            next_state = L_ERR;
          end else begin
            next_state = L_DATA;
          end
        end
        L_DATA: begin
          if (byte_idx == 2'd3 && word_idx == last_idx) begin
`ifdef RISCV_LOADER_CHECKSUM_EN
            next_state = L_CSUM;
`else
            next_state = L_DONE;
`endif
          end
        end
`ifdef RISCV_LOADER_CHECKSUM_EN
        L_CSUM:  next_state = (byte_data == csum) ? L_DONE : L_ERR;
`endif
        L_DONE, L_ERR: if (is_sync) next_state = L_LEN0;
        default: next_state = L_SYNC;
      endcase
    end
  end

  // Status outputs follow the state one cycle late, so load_done rises the
  // cycle after the final imem write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= L_SYNC;
      imem_wr_en    <= 1'b0;
      imem_wr_addr  <= '0;
      imem_wr_instr <= 32'd0;
      core_hold     <= 1'b1;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
      len_lo        <= 8'd0;
      last_idx      <= '0;
      word_idx      <= '0;
      byte_idx      <= 2'd0;
      word_buf      <= 24'd0;
`ifdef RISCV_LOADER_CHECKSUM_EN
      csum          <= 8'd0;
`endif
    end else begin
      state      <= next_state;
      imem_wr_en <= 1'b0;
      core_hold  <= (state != L_DONE);
      load_done  <= (state == L_DONE);
      load_err   <= (state == L_ERR);
      if (byte_valid) begin
        case (state)
          L_SYNC, L_DONE, L_ERR: begin
            if (is_sync) begin
              word_idx <= '0;
              byte_idx <= 2'd0;
`ifdef RISCV_LOADER_CHECKSUM_EN
              csum     <= 8'd0;
`endif
            end
          end
          L_LEN0: len_lo <= byte_data;
          L_LEN1: last_idx <= ADDR_W'(len_n - 16'd1);
          L_DATA: begin
            byte_idx <= byte_idx + 2'd1;
`ifdef RISCV_LOADER_CHECKSUM_EN
            csum     <= csum ^ byte_data;
`endif
            case (byte_idx)
              2'd0: word_buf[7:0]   <= byte_data;
              2'd1: word_buf[15:8]  <= byte_data;
              2'd2: word_buf[23:16] <= byte_data;
              default: begin
                imem_wr_en    <= 1'b1;
                imem_wr_addr  <= word_idx;
                imem_wr_instr <= {byte_data, word_buf};
                word_idx      <= word_idx + ADDR_W'(1);
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule
